// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch stage.
// Contents: PC/instruction widths, HALT opcode, queue entry payload type.
package fetch_pkg;

    localparam int unsigned PC_W    = 13;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 5;

    localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

    // One decoded-stage handoff: instruction plus the address it came from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundles the fetch stage's redirect, instruction-memory and decode handshakes.
// master: fetch_unit side (drives imem_req/imem_addr, dec_*, halted).
// slave : environment side (drives flush/PCIn, imem_gnt/rvalid/rdata, dec_ready).
interface fetch_if;
    import fetch_pkg::*;

    // redirect from execute
    logic               flush;
    logic [PC_W-1:0]    PCIn;
    // instruction memory
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    // decode handoff
    logic               dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [PC_W-1:0]    dec_pc;
    logic               dec_ready;
    logic               halted;

    modport master (
        input  flush, PCIn, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, halted
    );

    modport slave (
        output flush, PCIn, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, halted
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous instruction queue of fetch_entry_t with a registered head.
// Ports: clk, rst (sync, active-high), clear (drops all entries), push/din,
// pop, head/valid (entry 0 of a shift-down array), count (occupancy 0..DEPTH).
// Entry 0 is always the head so the decode-facing outputs come straight from flops.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  fetch_entry_t                  din,
    input  logic                          pop,
    output fetch_entry_t                  head,
    output logic                          valid,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_n [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic             valid_q;
    logic             do_pop;
    logic             do_push;

    // Next-state: shift down on pop, write at the first free slot on push.
    always_comb begin
        mem_n   = mem_q;
        cnt_n   = cnt_q;
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        if (clear) begin
            cnt_n = '0;
        end else begin
            if (do_pop) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    mem_n[i] = mem_q[i+1];
                end
            end
            if (do_push) begin
                if (do_pop) begin
                    mem_n[IDX_W'(cnt_q - CNT_W'(1))] = din;
                end else begin
                    mem_n[IDX_W'(cnt_q)] = din;
                end
            end
            cnt_n = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_n;
            cnt_q   <= cnt_n;
            valid_q <= (cnt_n != '0);
        end
    end

    assign head  = mem_q[0];
    assign valid = valid_q;
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem reads under a
// queue-credit limit, drops wrong-path responses after a redirect, and hands
// {pc, instr} pairs to decode through fetch_queue.
// Ports: clk, rst (sync, active-high), bus (fetch_if.master: flush/PCIn,
// imem_req/addr/gnt/rvalid/rdata, dec_valid/instr/pc/ready, halted).
// Build option: FETCH_HALT_EN -- decode accepting opcode 5'b00000 freezes
// fetch until the next flush or rst; without it halted is always 0.
// imem_req is combinational: it must drop in the same cycle as flush/rst.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_n;
    logic [PC_W-1:0]  resp_pc_q,  resp_pc_n;
    logic [CNT_W-1:0] inflight_q, inflight_n;
    logic [CNT_W-1:0] drop_q,     drop_n;
    logic             halted_q,   halted_n;

    logic             req_c;
    logic             credit;
    logic             grant;
    logic             rsp;
    logic             rsp_drop;
    logic             halt_hit;

    logic             q_clear;
    logic             q_push;
    logic             q_pop;
    fetch_entry_t     q_din;
    fetch_entry_t     q_head;
    logic             q_valid;
    logic [CNT_W-1:0] q_count;

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (q_clear),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .head  (q_head),
        .valid (q_valid),
        .count (q_count)
    );

    // Credit, response accounting, redirect and halt handling.
    always_comb begin
        fetch_pc_n = fetch_pc_q;
        resp_pc_n  = resp_pc_q;
        inflight_n = inflight_q;
        drop_n     = drop_q;
        halted_n   = halted_q;
        q_clear    = 1'b0;
        q_push     = 1'b0;
        q_pop      = 1'b0;
        q_din      = '{pc: resp_pc_q, instr: bus.imem_rdata};
        halt_hit   = 1'b0;

        // Queue slots already spoken for include every outstanding read.
        credit   = (SUM_W'(q_count) + SUM_W'(inflight_q)) < SUM_W'(QDEPTH);
        req_c    = !rst && !bus.flush && !halted_q && credit;
        grant    = req_c && bus.imem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp      = bus.imem_rvalid && (inflight_q != '0);
        rsp_drop = rsp && (drop_q != '0);

        inflight_n = inflight_q + CNT_W'(grant) - CNT_W'(rsp);
        if (grant) begin
            fetch_pc_n = fetch_pc_q + PC_W'(1);
        end
        if (rsp_drop) begin
            drop_n = drop_q - CNT_W'(1);
        end
        if (rsp && !rsp_drop) begin
            q_push    = 1'b1;
            resp_pc_n = resp_pc_q + PC_W'(1);
        end
        q_pop = q_valid && bus.dec_ready;

`ifdef FETCH_HALT_EN
        halt_hit = q_pop && (q_head.instr[INSTR_W-1 -: OPC_W] == OPC_HALT);
`else
        halt_hit = 1'b0;
`endif

        // Every read still outstanding after this cycle belongs to the old path.
        if (bus.flush) begin
            fetch_pc_n = bus.PCIn;
            resp_pc_n  = bus.PCIn;
            drop_n     = inflight_n;
            halted_n   = 1'b0;
            q_clear    = 1'b1;
            q_push     = 1'b0;
            q_pop      = 1'b0;
        end else if (halt_hit) begin
            drop_n   = inflight_n;
            halted_n = 1'b1;
            q_clear  = 1'b1;
            q_push   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_n;
            resp_pc_q  <= resp_pc_n;
            inflight_q <= inflight_n;
            drop_q     <= drop_n;
            halted_q   <= halted_n;
        end
    end

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.dec_valid = q_valid;
    assign bus.dec_instr = q_head.instr;
    assign bus.dec_pc    = q_head.pc;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap
// and the HALT opcode (behaviour follows the FETCH_HALT_EN build option).
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if bus ();
    fetch_if bus2 ();

    fetch_unit #(.QDEPTH(4), .RESET_PC(13'h0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.QDEPTH(4), .RESET_PC(13'h1FFE)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Memory contents: addr ^ 16'h5A00, optionally an opcode-0 word at address 5.
    function automatic logic [15:0] mdata(input logic [12:0] a, input bit z);
        if (z && (a == 13'd5)) return 16'h0005;
        return {3'b000, a} ^ 16'h5A00;
    endfunction

    // Fixed-latency memory for the main DUT (latency 1..3 cycles).
    int          lat     = 1;
    bit          opc0_en = 1'b0;
    logic        mv [1:4];
    logic [12:0] ma [1:4];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= 4; k++) begin
                mv[k] <= 1'b0;
                ma[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= 3; k++) begin
                mv[k] <= mv[k+1];
                ma[k] <= ma[k+1];
            end
            if (bus.imem_req && bus.imem_gnt) begin
                mv[lat] <= 1'b1;
                ma[lat] <= bus.imem_addr;
            end
        end
    end
    assign bus.imem_rvalid = mv[1];
    assign bus.imem_rdata  = mv[1] ? mdata(ma[1], opc0_en) : 16'h0000;

    // One-cycle memory for the wrap-around DUT.
    logic        mv2;
    logic [12:0] ma2;
    always @(posedge clk) begin
        if (rst) begin
            mv2 <= 1'b0;
            ma2 <= '0;
        end else begin
            mv2 <= bus2.imem_req && bus2.imem_gnt;
            ma2 <= bus2.imem_addr;
        end
    end
    assign bus2.imem_rvalid = mv2;
    assign bus2.imem_rdata  = mv2 ? mdata(ma2, 1'b0) : 16'h0000;

    // Grant counter and log of instructions accepted by decode.
    int           grant_cnt = 0;
    fetch_entry_t acc_q [$];
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.imem_req && bus.imem_gnt) grant_cnt++;
            if (bus.dec_valid && bus.dec_ready && !bus.flush)
                acc_q.push_back('{pc: bus.dec_pc, instr: bus.dec_instr});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle C0, the first cycle with rst=0.
    task automatic do_reset(input int l, input bit z, input logic rdy);
        rst          = 1'b1;
        lat          = l;
        opc0_en      = z;
        bus.flush    = 1'b0;
        bus.dec_ready = rdy;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;  bus.PCIn = '0;  bus.imem_gnt = 1'b1;  bus.dec_ready = 1'b1;
        bus2.flush = 1'b0; bus2.PCIn = '0; bus2.imem_gnt = 1'b1; bus2.dec_ready = 1'b1;
        repeat (2) cyc();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid); end
        n_cmp++; if (bus.dec_instr !== 16'h0000) begin n_bad++; $display("FAIL reset_dec_instr: got %h want 0000", bus.dec_instr); end
        n_cmp++; if (bus.dec_pc !== 13'h0000) begin n_bad++; $display("FAIL reset_dec_pc: got %h want 0000", bus.dec_pc); end
        n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        cyc();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL release_req: got %b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 13'h0000) begin n_bad++; $display("FAIL release_addr: got %h want 0000", bus.imem_addr); end
    endtask

    // Continues from C0 with dec_ready=1 and a 1-cycle memory.
    task automatic test_stream();
        for (int n = 1; n <= 16; n++) begin
            cyc();
            n_cmp++; if (bus.imem_addr !== 13'(n)) begin n_bad++; $display("FAIL stream_addr c%0d: got %h want %h", n, bus.imem_addr, 13'(n)); end
            if (n < 2) begin
                n_cmp++; if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want 0", n, bus.dec_valid); end
            end else begin
                n_cmp++; if (bus.dec_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want 1", n, bus.dec_valid); end
                n_cmp++; if (bus.dec_pc !== 13'(n - 2)) begin n_bad++; $display("FAIL stream_pc c%0d: got %h want %h", n, bus.dec_pc, 13'(n - 2)); end
                n_cmp++; if (bus.dec_instr !== mdata(13'(n - 2), 1'b0)) begin n_bad++; $display("FAIL stream_instr c%0d: got %h want %h", n, bus.dec_instr, mdata(13'(n - 2), 1'b0)); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0, 1'b0);
        grant_cnt = 0;
        repeat (10) cyc();
        n_cmp++; if (grant_cnt != 4) begin n_bad++; $display("FAIL bp_grants: got %0d want 4", grant_cnt); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req: got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 13'h0004) begin n_bad++; $display("FAIL bp_addr: got %h want 0004", bus.imem_addr); end
        n_cmp++; if (bus.dec_pc !== 13'h0000) begin n_bad++; $display("FAIL bp_head: got %h want 0000", bus.dec_pc); end
        acc_q.delete();
        bus.dec_ready = 1'b1;
        repeat (6) cyc();
        n_cmp++; if (acc_q.size() < 4) begin n_bad++; $display("FAIL bp_drain_count: got %0d want >=4", acc_q.size()); end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            n_cmp++; if (acc_q[i].pc !== 13'(i)) begin n_bad++; $display("FAIL bp_drain_pc%0d: got %h want %h", i, acc_q[i].pc, 13'(i)); end
            n_cmp++; if (acc_q[i].instr !== mdata(13'(i), 1'b0)) begin n_bad++; $display("FAIL bp_drain_instr%0d: got %h want %h", i, acc_q[i].instr, mdata(13'(i), 1'b0)); end
        end
    endtask

    task automatic test_flush_stale();
        do_reset(3, 1'b0, 1'b1);
        repeat (2) cyc();              // C2: reads 0 and 1 outstanding
        bus.flush = 1'b1;
        bus.PCIn  = 13'h0100;
        acc_q.delete();
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL fls_req_during: got %b want 0", bus.imem_req); end
        cyc();                         // C3
        bus.flush = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL fls_req_after: got %b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 13'h0100) begin n_bad++; $display("FAIL fls_addr: got %h want 0100", bus.imem_addr); end
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL fls_valid_c3: got %b want 0", bus.dec_valid); end
        for (int c = 4; c <= 6; c++) begin
            cyc();
            n_cmp++; if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL fls_valid_c%0d: got %b want 0", c, bus.dec_valid); end
        end
        cyc();                         // C7
        n_cmp++; if (bus.dec_valid !== 1'b1) begin n_bad++; $display("FAIL fls_valid_c7: got %b want 1", bus.dec_valid); end
        n_cmp++; if (bus.dec_pc !== 13'h0100) begin n_bad++; $display("FAIL fls_pc_c7: got %h want 0100", bus.dec_pc); end
        n_cmp++; if (bus.dec_instr !== 16'h5B00) begin n_bad++; $display("FAIL fls_instr_c7: got %h want 5B00", bus.dec_instr); end
        cyc();                         // C8
        n_cmp++; if (bus.dec_pc !== 13'h0101) begin n_bad++; $display("FAIL fls_pc_c8: got %h want 0101", bus.dec_pc); end
        n_cmp++; if (acc_q.size() != 1) begin n_bad++; $display("FAIL fls_accepted: got %0d want 1", acc_q.size()); end
    endtask

    task automatic test_flush_collide();
        do_reset(1, 1'b0, 1'b1);
        repeat (5) cyc();              // C5: head pc 3, response for pc 4 arriving
        n_cmp++; if (bus.dec_pc !== 13'h0003) begin n_bad++; $display("FAIL col_head: got %h want 0003", bus.dec_pc); end
        bus.flush = 1'b1;
        bus.PCIn  = 13'h0040;
        acc_q.delete();
        cyc();                         // C6
        bus.flush = 1'b0;
        #1;
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL col_valid_c6: got %b want 0", bus.dec_valid); end
        n_cmp++; if (bus.imem_addr !== 13'h0040) begin n_bad++; $display("FAIL col_addr: got %h want 0040", bus.imem_addr); end
        cyc();                         // C7
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL col_valid_c7: got %b want 0", bus.dec_valid); end
        cyc();                         // C8
        n_cmp++; if (bus.dec_pc !== 13'h0040) begin n_bad++; $display("FAIL col_pc_c8: got %h want 0040", bus.dec_pc); end
        n_cmp++; if (bus.dec_instr !== 16'h5A40) begin n_bad++; $display("FAIL col_instr_c8: got %h want 5A40", bus.dec_instr); end
        cyc();                         // C9
        n_cmp++; if (acc_q.size() != 1) begin n_bad++; $display("FAIL col_accepted: got %0d want 1", acc_q.size()); end
    endtask

    task automatic test_wrap();
        logic [12:0] wpc [3];
        logic [15:0] wins [3];
        wpc  = '{13'h1FFE, 13'h1FFF, 13'h0000};
        wins = '{16'h45FE, 16'h45FF, 16'h5A00};
        do_reset(1, 1'b0, 1'b1);
        n_cmp++; if (bus2.imem_addr !== 13'h1FFE) begin n_bad++; $display("FAIL wrap_addr_c0: got %h want 1FFE", bus2.imem_addr); end
        repeat (2) cyc();
        n_cmp++; if (bus2.imem_addr !== 13'h0000) begin n_bad++; $display("FAIL wrap_addr_c2: got %h want 0000", bus2.imem_addr); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            n_cmp++; if (bus2.dec_pc !== wpc[i]) begin n_bad++; $display("FAIL wrap_pc%0d: got %h want %h", i, bus2.dec_pc, wpc[i]); end
            n_cmp++; if (bus2.dec_instr !== wins[i]) begin n_bad++; $display("FAIL wrap_instr%0d: got %h want %h", i, bus2.dec_instr, wins[i]); end
        end
    endtask

`ifdef FETCH_HALT_EN
    task automatic test_halt();
        do_reset(1, 1'b1, 1'b1);
        repeat (7) cyc();              // C7: opcode-0 word at pc 5 accepted
        n_cmp++; if (bus.dec_pc !== 13'h0005) begin n_bad++; $display("FAIL halt_pc: got %h want 0005", bus.dec_pc); end
        n_cmp++; if (bus.dec_instr !== 16'h0005) begin n_bad++; $display("FAIL halt_instr: got %h want 0005", bus.dec_instr); end
        for (int c = 8; c <= 11; c++) begin
            cyc();
            n_cmp++; if (bus.halted !== 1'b1) begin n_bad++; $display("FAIL halt_flag_c%0d: got %b want 1", c, bus.halted); end
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_req_c%0d: got %b want 0", c, bus.imem_req); end
            n_cmp++; if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL halt_valid_c%0d: got %b want 0", c, bus.dec_valid); end
        end
        cyc();                         // C12
        bus.flush = 1'b1;
        bus.PCIn  = 13'h0020;
        cyc();                         // C13
        bus.flush = 1'b0;
        #1;
        n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL unhalt_flag: got %b want 0", bus.halted); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL unhalt_req: got %b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 13'h0020) begin n_bad++; $display("FAIL unhalt_addr: got %h want 0020", bus.imem_addr); end
        repeat (2) cyc();              // C15
        n_cmp++; if (bus.dec_pc !== 13'h0020) begin n_bad++; $display("FAIL unhalt_pc: got %h want 0020", bus.dec_pc); end
        n_cmp++; if (bus.dec_instr !== 16'h5A20) begin n_bad++; $display("FAIL unhalt_instr: got %h want 5A20", bus.dec_instr); end
    endtask
`else
    task automatic test_opc0_passthrough();
        do_reset(1, 1'b1, 1'b1);
        repeat (7) cyc();              // C7: opcode-0 word at pc 5 accepted
        n_cmp++; if (bus.dec_instr !== 16'h0005) begin n_bad++; $display("FAIL opc0_instr: got %h want 0005", bus.dec_instr); end
        cyc();                         // C8
        n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL opc0_halted: got %b want 0", bus.halted); end
        n_cmp++; if (bus.dec_valid !== 1'b1) begin n_bad++; $display("FAIL opc0_valid: got %b want 1", bus.dec_valid); end
        n_cmp++; if (bus.dec_pc !== 13'h0006) begin n_bad++; $display("FAIL opc0_pc: got %h want 0006", bus.dec_pc); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL opc0_req: got %b want 1", bus.imem_req); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_stale();
        test_flush_collide();
        test_wrap();
`ifdef FETCH_HALT_EN
        test_halt();
`else
        test_opc0_passthrough();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
